// File: rtl/sym_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sym_pkg
//  Description : Shared types, constants and helpers for the symbol-counting
//                round controller (state encoding, LFSR taps, counter limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package sym_pkg;

    // Round controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHOW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          COUNT_W   = 8;
    localparam logic [COUNT_W-1:0] SAT_MAX = 8'hFF;

    // One step of the right-shifting Galois LFSR; a nonzero state never maps to 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Increment that sticks at SAT_MAX instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        sat_inc = (v == SAT_MAX) ? v : v + COUNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sym_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : sym_lfsr
//  Description : 16-bit Galois LFSR that steps only when advance is high.
//                Loads the seed on reset; otherwise free of round boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_lfsr
    import sym_pkg::*;
(
    input  logic        Clk100M,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] r_state_q;
    logic [15:0] w_state_d;

    // Next LFSR value: step only on request
    always_comb begin
        w_state_d = r_state_q;
        if (advance) begin
            w_state_d = lfsr_next(r_state_q);
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_state_q <= seed;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign state = r_state_q;

endmodule
`default_nettype wire

// File: rtl/sym_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sym_round_ctrl
//  Description : Runs one symbol-counting round: shows a pseudo-random symbol
//                stream, counts magic symbols and user presses, and signals
//                start/stop of the round to the scoring block.
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_round_ctrl
    import sym_pkg::*;
#(
    parameter int                SYM_PERIOD  = 100_000_000,
    parameter int                NUM_SYMBOLS = 32,
    parameter int                SYM_W       = 4,
    parameter logic [SYM_W-1:0]  MAGIC       = 4'hA,
    parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
    input  logic               Clk100M,
    input  logic               reset,
    input  logic               go,
    input  logic               userPress,
    output logic [SYM_W-1:0]   symbol,
    output logic               symbolValid,
    output logic               start,
    output logic               stop,
    output logic               busy,
    output logic [COUNT_W-1:0] userCount,
    output logic [COUNT_W-1:0] magicSymbolCount
);

    localparam int                  TIMER_W      = $clog2(SYM_PERIOD);
    localparam logic [TIMER_W-1:0]  C_TIMER_LAST = TIMER_W'(SYM_PERIOD - 1);
    localparam logic [7:0]          C_NUM_SYM    = 8'(NUM_SYMBOLS);

    // Registered state
    state_e              r_state_q;
    logic [TIMER_W-1:0]  r_timer_q;
    logic [7:0]          r_sym_idx_q;
    logic                r_go_prev_q;
    logic                r_press_prev_q;
    logic [SYM_W-1:0]    r_symbol_q;
    logic                r_symbol_valid_q;
    logic                r_start_q;
    logic                r_stop_q;
    logic                r_busy_q;
    logic [COUNT_W-1:0]  r_user_cnt_q;
    logic [COUNT_W-1:0]  r_magic_cnt_q;

    // Next-state values
    state_e              w_state_d;
    logic [TIMER_W-1:0]  w_timer_d;
    logic [7:0]          w_sym_idx_d;
    logic [SYM_W-1:0]    w_symbol_d;
    logic                w_symbol_valid_d;
    logic                w_start_d;
    logic                w_stop_d;
    logic                w_busy_d;
    logic [COUNT_W-1:0]  w_user_cnt_d;
    logic [COUNT_W-1:0]  w_magic_cnt_d;

    logic                w_go_edge;
    logic                w_press_edge;
    logic                w_lfsr_adv;
    logic [15:0]         w_lfsr_state;
    logic [SYM_W-1:0]    w_new_sym;
    logic                w_magic_hit;

    sym_lfsr u_lfsr (
        .Clk100M (Clk100M),
        .reset   (reset),
        .advance (w_lfsr_adv),
        .seed    (LFSR_SEED),
        .state   (w_lfsr_state)
    );

    // The symbol loaded is taken from the value the LFSR steps to this cycle
    assign w_new_sym    = SYM_W'(lfsr_next(w_lfsr_state));
    assign w_magic_hit  = (w_new_sym == MAGIC);
    assign w_go_edge    = go & ~r_go_prev_q;
    assign w_press_edge = userPress & ~r_press_prev_q;

    // Round sequencing, symbol timing and counter updates
    always_comb begin
        w_state_d        = r_state_q;
        w_timer_d        = r_timer_q;
        w_sym_idx_d      = r_sym_idx_q;
        w_symbol_d       = r_symbol_q;
        w_symbol_valid_d = 1'b0;
        w_user_cnt_d     = r_user_cnt_q;
        w_magic_cnt_d    = r_magic_cnt_q;
        w_lfsr_adv       = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (w_go_edge) begin
                    w_state_d = START;
                end
            end
            START: begin
                w_user_cnt_d  = '0;
                w_magic_cnt_d = '0;
                w_sym_idx_d   = '0;
                w_timer_d     = '0;
                w_state_d     = SHOW;
            end
            SHOW: begin
                // sym_idx==0 only on the first SHOW cycle, which loads immediately
                if ((r_sym_idx_q == 8'd0) ||
                    ((r_timer_q == C_TIMER_LAST) && (r_sym_idx_q != C_NUM_SYM))) begin
                    w_lfsr_adv       = 1'b1;
                    w_symbol_d       = w_new_sym;
                    w_symbol_valid_d = 1'b1;
                    w_timer_d        = '0;
                    w_sym_idx_d      = r_sym_idx_q + 8'd1;
                    if (w_magic_hit) begin
                        w_magic_cnt_d = sat_inc(r_magic_cnt_q);
                    end
                end else if (r_timer_q == C_TIMER_LAST) begin
                    w_state_d = DONE;
                end else begin
                    w_timer_d = r_timer_q + TIMER_W'(1);
                end
                if (w_press_edge) begin
                    w_user_cnt_d = sat_inc(r_user_cnt_q);
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered
        w_start_d = (w_state_d == START);
        w_stop_d  = (w_state_d == DONE);
        w_busy_d  = (w_state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_state_q        <= IDLE;
            r_timer_q        <= '0;
            r_sym_idx_q      <= '0;
            r_go_prev_q      <= 1'b0;
            r_press_prev_q   <= 1'b0;
            r_symbol_q       <= '0;
            r_symbol_valid_q <= 1'b0;
            r_start_q        <= 1'b0;
            r_stop_q         <= 1'b0;
            r_busy_q         <= 1'b0;
            r_user_cnt_q     <= '0;
            r_magic_cnt_q    <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_timer_q        <= w_timer_d;
            r_sym_idx_q      <= w_sym_idx_d;
            r_go_prev_q      <= go;
            r_press_prev_q   <= userPress;
            r_symbol_q       <= w_symbol_d;
            r_symbol_valid_q <= w_symbol_valid_d;
            r_start_q        <= w_start_d;
            r_stop_q         <= w_stop_d;
            r_busy_q         <= w_busy_d;
            r_user_cnt_q     <= w_user_cnt_d;
            r_magic_cnt_q    <= w_magic_cnt_d;
        end
    end

    assign symbol           = r_symbol_q;
    assign symbolValid      = r_symbol_valid_q;
    assign start            = r_start_q;
    assign stop             = r_stop_q;
    assign busy             = r_busy_q;
    assign userCount        = r_user_cnt_q;
    assign magicSymbolCount = r_magic_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sym_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sym_round_ctrl
//  Description : Scoreboard bench for sym_round_ctrl. Stimulus pushes expected
//                symbols and end-of-round counts; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sym_round_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int user;
        int magic;
    } cnt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: normal round (8 symbols x 4 cycles)
    logic       a_reset, a_go, a_press;
    logic [3:0] a_symbol;
    logic       a_symbolValid, a_start, a_stop, a_busy;
    logic [7:0] a_userCount, a_magicCount;

    // Instance B: long round for saturation
    logic       b_reset, b_go, b_press;
    logic [3:0] b_symbol;
    logic       b_symbolValid, b_start, b_stop, b_busy;
    logic [7:0] b_userCount, b_magicCount;

    sym_round_ctrl #(
        .SYM_PERIOD(4), .NUM_SYMBOLS(8), .SYM_W(4), .MAGIC(4'hA), .LFSR_SEED(SEED)
    ) dut_a (
        .Clk100M(clk), .reset(a_reset), .go(a_go), .userPress(a_press),
        .symbol(a_symbol), .symbolValid(a_symbolValid), .start(a_start),
        .stop(a_stop), .busy(a_busy), .userCount(a_userCount),
        .magicSymbolCount(a_magicCount)
    );

    sym_round_ctrl #(
        .SYM_PERIOD(4), .NUM_SYMBOLS(255), .SYM_W(4), .MAGIC(4'hA), .LFSR_SEED(SEED)
    ) dut_b (
        .Clk100M(clk), .reset(b_reset), .go(b_go), .userPress(b_press),
        .symbol(b_symbol), .symbolValid(b_symbolValid), .start(b_start),
        .stop(b_stop), .busy(b_busy), .userCount(b_userCount),
        .magicSymbolCount(b_magicCount)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  exp_sym_q[$];
    cnt_t        exp_cnt_q[$];
    logic [15:0] m_lfsr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event missing expected event present", name);
    endtask

    // Reference Galois LFSR: shift right, xor taps when the dropped bit was 1
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Queue expectations for a full 8-symbol round on instance A
    task automatic plan_round(input int exp_user);
        cnt_t c;
        int   mg;
        mg = 0;
        for (int i = 0; i < 8; i++) begin
            m_lfsr = ref_step(m_lfsr);
            exp_sym_q.push_back(m_lfsr[3:0]);
            if (m_lfsr[3:0] == 4'hA) mg++;
        end
        c.user  = exp_user;
        c.magic = mg;
        exp_cnt_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stop(input bit sel_b, input int budget, input string name);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            tick();
            n++;
            found = sel_b ? b_stop : a_stop;
        end
        if (!found) fail_now(name);
    endtask

    // ---------------- Monitor / scoreboard for instance A ----------------
    int go_cyc = 0;
    int first_valid_cyc = 0;
    int last_valid_cyc = 0;
    int valid_cnt = 0;
    int n_start = 0;
    int n_stop = 0;
    bit stop_prev = 1'b0;

    always @(negedge clk) begin
        if (stop_prev) check("busy_after_stop", a_busy, 0);
        stop_prev = a_stop;
        if (a_start) begin
            n_start++;
            check("start_latency", cyc - go_cyc, 1);
            check("busy_at_start", a_busy, 1);
            valid_cnt = 0;
        end
        if (a_symbolValid) begin
            if (exp_sym_q.size() == 0) begin
                fail_now("symbol_unexpected");
            end else begin
                check("symbol", a_symbol, exp_sym_q.pop_front());
            end
            if (valid_cnt == 0) first_valid_cyc = cyc;
            else check("symbol_gap", cyc - last_valid_cyc, 4);
            last_valid_cyc = cyc;
            valid_cnt++;
        end
        if (a_stop) begin
            cnt_t c;
            n_stop++;
            check("stop_after_first_symbol", cyc - first_valid_cyc, 32);
            check("symbols_per_round", valid_cnt, 8);
            if (exp_cnt_q.size() == 0) begin
                fail_now("stop_unexpected");
            end else begin
                c = exp_cnt_q.pop_front();
                check("userCount_at_stop", a_userCount, c.user);
                check("magicCount_at_stop", a_magicCount, c.magic);
            end
        end
    end

    // ---------------- Stimulus ----------------
    initial begin
        int u0, m0, s0, t0;
        force dut_b.w_magic_hit = 1'b1;
        a_reset = 1'b1; a_go = 1'b0; a_press = 1'b0;
        b_reset = 1'b1; b_go = 1'b0; b_press = 1'b0;
        m_lfsr  = SEED;
        repeat (3) tick();
        a_reset = 1'b0;
        b_reset = 1'b0;
        tick();

        // Reset state
        check("rst_symbol", a_symbol, 0);
        check("rst_symbolValid", a_symbolValid, 0);
        check("rst_start", a_start, 0);
        check("rst_stop", a_stop, 0);
        check("rst_busy", a_busy, 0);
        check("rst_userCount", a_userCount, 0);
        check("rst_magicCount", a_magicCount, 0);

        // Round 1: timing, symbol stream, magic count, counts frozen after stop
        plan_round(0);
        go_cyc = cyc; a_go = 1'b1; tick(); a_go = 1'b0;
        wait_stop(1'b0, 60, "round1_stop_timeout");
        u0 = a_userCount; m0 = a_magicCount;
        repeat (10) tick();
        check("userCount_frozen", a_userCount, u0);
        check("magicCount_frozen", a_magicCount, m0);
        check("idle_busy", a_busy, 0);
        check("round1_starts", n_start, 1);
        check("round1_stops", n_stop, 1);

        // Round 2: five pulses plus one long hold in SHOW, two presses in IDLE
        plan_round(6);
        go_cyc = cyc; a_go = 1'b1; tick(); a_go = 1'b0;
        repeat (2) tick();
        repeat (5) begin a_press = 1'b1; tick(); a_press = 1'b0; tick(); end
        a_press = 1'b1; repeat (12) tick(); a_press = 1'b0;
        wait_stop(1'b0, 60, "round2_stop_timeout");
        tick();
        repeat (2) begin a_press = 1'b1; tick(); a_press = 1'b0; tick(); end
        check("userCount_idle_presses_ignored", a_userCount, 6);

        // Round 3: go toggles during SHOW are ignored
        plan_round(0);
        s0 = n_start; t0 = n_stop;
        go_cyc = cyc; a_go = 1'b1; tick(); a_go = 1'b0;
        repeat (5) tick();
        repeat (3) begin a_go = 1'b1; tick(); a_go = 1'b0; tick(); end
        wait_stop(1'b0, 60, "round3_stop_timeout");
        repeat (6) tick();
        check("toggle_single_start", n_start - s0, 1);
        check("toggle_single_stop", n_stop - t0, 1);

        // Round 4: reset mid-SHOW aborts silently, next round restarts from seed
        plan_round(0);
        go_cyc = cyc; a_go = 1'b1; tick(); a_go = 1'b0;
        repeat (12) tick();
        t0 = n_stop;
        a_reset = 1'b1;
        exp_sym_q.delete();
        exp_cnt_q.delete();
        m_lfsr = SEED;
        tick();
        check("abort_symbol", a_symbol, 0);
        check("abort_symbolValid", a_symbolValid, 0);
        check("abort_start", a_start, 0);
        check("abort_stop", a_stop, 0);
        check("abort_busy", a_busy, 0);
        check("abort_userCount", a_userCount, 0);
        check("abort_magicCount", a_magicCount, 0);
        a_reset = 1'b0;
        repeat (50) tick();
        check("no_stop_after_abort", n_stop, t0);
        plan_round(0);
        go_cyc = cyc; a_go = 1'b1; tick(); a_go = 1'b0;
        repeat (2) tick();
        // 16'hACE1 steps to 16'hE270, so the first symbol is 0
        check("first_valid_after_reset", a_symbolValid, 1);
        check("first_symbol_after_reset", a_symbol, 4'h0);
        wait_stop(1'b0, 60, "round4_stop_timeout");
        tick();

        // Instance B: every symbol magic, 300 presses -> both counts saturate
        b_go = 1'b1; tick(); b_go = 1'b0;
        repeat (3) tick();
        repeat (300) begin b_press = 1'b1; tick(); b_press = 1'b0; tick(); end
        wait_stop(1'b1, 1500, "sat_stop_timeout");
        check("sat_userCount", b_userCount, 255);
        check("sat_magicCount", b_magicCount, 255);
        tick();
        check("sat_busy_after", b_busy, 0);

        check("symbols_outstanding", exp_sym_q.size(), 0);
        check("counts_outstanding", exp_cnt_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
